// File: rtl/sm_argmax.sv
// Argmax over CLASS_COUNT activations: serial fetch, 1-cycle read latency, done held until reset.
// Optional SM_ARGMAX_MARGIN_EN adds second_val/margin outputs (runner-up value and best-minus-runner-up).
module sm_argmax #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int ADDR_WIDTH    = 16,
  parameter  int ADDR_BASE_OUT = 0,
  parameter  int CLASS_COUNT   = 10,
  localparam int IDX_WIDTH     = $clog2(CLASS_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  reset,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_val
`ifdef SM_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_WIDTH-1:0] second_val,
  output logic [DATA_WIDTH-1:0] margin
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(CLASS_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(ADDR_BASE_OUT);

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  cmp_v;
  logic [IDX_WIDTH-1:0]  cmp_idx;
  logic                  accept, load_first, new_best;
  logic [DATA_WIDTH-1:0] val_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        mem_addr = BASE + ADDR_WIDTH'(rd_idx);
        if (rd_idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (reset) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The first word of a scan seeds the best unconditionally; later words need a strict win,
  // so on ties the lowest index survives.
  assign accept     = (state == S_IDLE) && start;
  assign load_first = cmp_v && (cmp_idx == '0);
  assign new_best   = cmp_v && (load_first || (mem_rd_data > class_val));

  always_comb begin
    val_nxt = class_val;
    if (accept)        val_nxt = '0;
    else if (new_best) val_nxt = mem_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      cmp_v     <= 1'b0;
      cmp_idx   <= '0;
      class_idx <= '0;
      class_val <= '0;
    end else begin
      if (accept)                  rd_idx <= '0;
      else if (state == S_FETCH)   rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      cmp_v   <= (state == S_FETCH);
      cmp_idx <= rd_idx;
      if (accept)        class_idx <= '0;
      else if (new_best) class_idx <= cmp_idx;
      class_val <= val_nxt;
    end
  end

`ifdef SM_ARGMAX_MARGIN_EN
  logic [DATA_WIDTH-1:0] sec_nxt;

  // A dethroned best becomes the runner-up; an equal-to-best word makes the margin zero.
  always_comb begin
    sec_nxt = second_val;
    if (accept) begin
      sec_nxt = '0;
    end else if (cmp_v && !load_first) begin
      if (new_best)
        sec_nxt = class_val;
      else if ((mem_rd_data > second_val) || (mem_rd_data == class_val))
        sec_nxt = mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_val <= '0;
      margin     <= '0;
    end else begin
      second_val <= sec_nxt;
      margin     <= val_nxt - sec_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sm_argmax.sv
module tb_sm_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        reset;
  logic        done;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic [3:0]  class_idx;
  logic [7:0]  class_val;
`ifdef SM_ARGMAX_MARGIN_EN
  logic [7:0]  second_val;
  logic [7:0]  margin;
`endif

  logic [7:0] mem [16];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sm_argmax dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reset(reset),
    .done(done), .busy(busy), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .class_idx(class_idx), .class_val(class_val)
`ifdef SM_ARGMAX_MARGIN_EN
    , .second_val(second_val), .margin(margin)
`endif
  );

  // Registered memory with one cycle of read latency; addresses beyond the table read as zero.
  always @(posedge clk) begin
    if (mem_addr < 16'd10) mem_rd_data <= mem[mem_addr[3:0]];
    else                   mem_rd_data <= 8'h00;
  end

  // Reference: first index holding the maximum, and the largest value among the other entries.
  task automatic ref_model(output int ei, output int ev, output int es);
    ei = 0; ev = mem[0];
    for (int k = 1; k < 10; k++) if (mem[k] > ev) begin ev = mem[k]; ei = k; end
    es = 0;
    for (int k = 0; k < 10; k++) if (k != ei && mem[k] > es) es = mem[k];
  endtask

  task automatic load_mem(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    int v[10];
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    for (int k = 0; k < 16; k++) mem[k] = (k < 10) ? 8'(v[k]) : 8'h00;
  endtask

  task automatic to_idle();
    if (done === 1'b1) begin
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
    end
  endtask

  // glitch=1 keeps start and reset high throughout the scan; both must be ignored there.
  task automatic run_scan(input string tag, input bit glitch);
    int cyc, ei, ev, es;
    ref_model(ei, ev, es);
    to_idle();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = glitch;
      reset = glitch;
      if (cyc == 5) begin
        total++;
        if (busy !== 1'b1 || mem_addr !== 16'd4)
          $display("FAIL %s fetch5 busy=%0b addr=%0d required busy=1 addr=4", tag, busy, mem_addr);
        else passed++;
      end
      if (cyc == 11) begin
        total++;
        if (busy !== 1'b1 || mem_addr !== 16'd0 || done !== 1'b0)
          $display("FAIL %s drain busy=%0b addr=%0d done=%0b required 1/0/0", tag, busy, mem_addr, done);
        else passed++;
      end
      if (done === 1'b1) break;
    end
    start = 1'b0;
    reset = 1'b0;
    total++;
    if (cyc !== 12) $display("FAIL %s done_cycle got %0d required 12", tag, cyc);
    else passed++;
    total++;
    if (class_idx !== 4'(ei) || class_val !== 8'(ev))
      $display("FAIL %s result idx=%0d val=%0d required idx=%0d val=%0d", tag, class_idx, class_val, ei, ev);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL %s busy_at_done got %0b required 0", tag, busy);
    else passed++;
`ifdef SM_ARGMAX_MARGIN_EN
    total++;
    if (second_val !== 8'(es) || margin !== 8'(ev - es))
      $display("FAIL %s margin second=%0d margin=%0d required second=%0d margin=%0d",
               tag, second_val, margin, es, ev - es);
    else passed++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; reset = 1'b0;
    load_mem(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'd0 || class_idx !== 4'd0 || class_val !== 8'd0)
      $display("FAIL reset_state done=%0b busy=%0b addr=%0d idx=%0d val=%0d required all 0",
               done, busy, mem_addr, class_idx, class_val);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL idle_no_start done=%0b busy=%0b required 0/0", done, busy);
    else passed++;
  endtask

  task automatic test_basic();
    load_mem(3, 7, 2, 9, 1, 0, 4, 8, 5, 6);
    run_scan("basic", 1'b0);
  endtask

  task automatic test_tie();
    load_mem(5, 5, 200, 5, 5, 5, 200, 5, 5, 5);
    run_scan("tie", 1'b0);
  endtask

  task automatic test_last();
    load_mem(0, 0, 0, 0, 0, 0, 0, 0, 0, 255);
    run_scan("last", 1'b0);
  endtask

  task automatic test_rst_mid_scan();
    load_mem(3, 7, 2, 9, 1, 0, 4, 8, 5, 6);
    to_idle();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'd0 || class_idx !== 4'd0 || class_val !== 8'd0)
      $display("FAIL mid_scan_reset done=%0b busy=%0b addr=%0d idx=%0d val=%0d required all 0",
               done, busy, mem_addr, class_idx, class_val);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    run_scan("after_rst", 1'b0);
  endtask

  task automatic test_done_hold();
    int ei, ev, es;
    load_mem(1, 2, 3, 4, 60, 6, 7, 8, 9, 10);
    run_scan("pre_hold", 1'b0);
    ref_model(ei, ev, es);
    start = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_hold done=%0b busy=%0b required 1/0", done, busy);
    else passed++;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || class_idx !== 4'(ei) || class_val !== 8'(ev))
      $display("FAIL reset_to_idle done=%0b busy=%0b idx=%0d val=%0d required 0/0/%0d/%0d",
               done, busy, class_idx, class_val, ei, ev);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || class_idx !== 4'(ei) || class_val !== 8'(ev))
      $display("FAIL idle_hold done=%0b idx=%0d val=%0d required 0/%0d/%0d", done, class_idx, class_val, ei, ev);
    else passed++;
  endtask

  task automatic test_margin();
    load_mem(10, 50, 49, 0, 0, 0, 0, 0, 0, 0);
    run_scan("margin_near", 1'b0);
    load_mem(7, 7, 7, 7, 7, 7, 7, 7, 7, 7);
    run_scan("margin_flat", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 10; k++)
        mem[k] = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      run_scan($sformatf("rand%0d", i), (i % 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_last();
    test_rst_mid_scan();
    test_done_hold();
    test_margin();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
